// File: rtl/event_drain_32_pkg.sv
// event_drain_32_pkg: shared widths and reset constant for the event drain
package event_drain_32_pkg;
    localparam int WIDTH_D = 32;
    localparam int IDX_W_D = 5;
    localparam logic [WIDTH_D-1:0] PENDING_RST = '0;
endpackage

// File: rtl/prio_enc_32.sv
// prio_enc_32: combinational lowest-set-bit encoder
module prio_enc_32
    import event_drain_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int IDX_W = IDX_W_D
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/event_drain_32.sv
// event_drain_32: OR-accumulates events and drains them lowest-index-first over valid/ready
module event_drain_32
    import event_drain_32_pkg::*;
#(
    parameter int WIDTH = WIDTH_D,
    parameter int IDX_W = IDX_W_D
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] evt,
    input  logic [WIDTH-1:0] mask,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [WIDTH-1:0] pending,
    output logic             overflow
);
    logic [IDX_W-1:0] sel;
    logic             found;
    logic             slot_free;
    logic             load;
    logic [WIDTH-1:0] load_vec;

    prio_enc_32 #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
        .vec   (pending & mask),
        .idx   (sel),
        .found (found)
    );

    assign slot_free = ~out_valid | out_ready;
    assign load      = slot_free & found;
    assign load_vec  = {{(WIDTH-1){1'b0}}, load} << sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= WIDTH'(PENDING_RST);
            out_valid <= 1'b0;
            out_index <= '0;
            overflow  <= 1'b0;
        end else begin
            pending   <= (pending & ~load_vec) | evt;
            out_valid <= slot_free ? found : out_valid;
            out_index <= load ? sel : out_index;
            overflow  <= |(evt & pending & ~load_vec) | (overflow & ~clr_ovf);
        end
    end
endmodule

// File: tb/tb_event_drain_32.sv
// tb_event_drain_32: directed plus randomized check of event_drain_32 against a bit-level model
module tb_event_drain_32;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] evt, mask;
    logic        out_ready, clr_ovf;
    logic        out_valid, overflow;
    logic [4:0]  out_index;
    logic [31:0] pending;
    int          total = 0, bad = 0;
    logic [31:0] m_pend;
    logic        m_valid, m_ovf;
    logic [4:0]  m_idx;

    event_drain_32 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .evt       (evt),
        .mask      (mask),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_index (out_index),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_valid = 1'b0;
        m_idx = '0;
        m_ovf = 1'b0;
    endtask

    task automatic step();
        logic [31:0] np;
        logic        nv, no, free, ld, hit, taken;
        logic [4:0]  ni;
        int          sel;
        free = !m_valid || out_ready;
        sel = -1;
        for (int i = 0; i < 32; i++)
            if (m_pend[i] && mask[i]) begin
                sel = i;
                break;
            end
        ld = free && sel >= 0;
        hit = 1'b0;
        np = m_pend;
        for (int i = 0; i < 32; i++) begin
            taken = ld && sel == i;
            if (evt[i] && m_pend[i] && !taken) hit = 1'b1;
            if (taken) np[i] = 1'b0;
            if (evt[i]) np[i] = 1'b1;
        end
        nv = free ? (sel >= 0) : m_valid;
        ni = ld ? 5'(sel) : m_idx;
        no = hit || (m_ovf && !clr_ovf);
        @(posedge clk);
        #1;
        m_pend = np;
        m_valid = nv;
        m_idx = ni;
        m_ovf = no;
        check("pend", pending, m_pend);
        check("valid", 32'(out_valid), 32'(m_valid));
        check("index", 32'(out_index), 32'(m_idx));
        check("ovf", 32'(overflow), 32'(m_ovf));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_pend", pending, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        evt = '1;
        mask = '1;
        out_ready = 1'b1;
        clr_ovf = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        evt = '0;
        reset_n = 1'b1;
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pend", pending, 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        evt = 32'h10;
        step();
        evt = '0;
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_idx", 32'(out_index), 32'd4);
        check("single_pend", pending, 32'd0);
        step();
        check("single_done", 32'(out_valid), 32'd0);

        evt = 32'h8000_0005;
        step();
        evt = '0;
        step();
        check("burst0", 32'(out_index), 32'd0);
        step();
        check("burst1", 32'(out_index), 32'd2);
        step();
        check("burst2", 32'(out_index), 32'd31);
        step();
        check("burst_done", 32'(out_valid), 32'd0);

        evt = 32'h6;
        out_ready = 1'b0;
        step();
        evt = '0;
        repeat (4) step();
        check("bp_idx", 32'(out_index), 32'd1);
        check("bp_pend", pending, 32'h4);
        out_ready = 1'b1;
        step();
        check("bp_next", 32'(out_index), 32'd2);
        step();

        mask = 32'hFFFF_FFFE;
        evt = 32'h3;
        step();
        evt = '0;
        step();
        check("mask_idx", 32'(out_index), 32'd1);
        step();
        check("mask_pend", pending, 32'h1);
        check("mask_idle", 32'(out_valid), 32'd0);
        mask = '1;
        step();
        check("mask_bit0", 32'(out_index), 32'd0);
        step();

        evt = 32'h9;
        step();
        evt = '0;
        out_ready = 1'b0;
        step();
        evt = 32'h8;
        step();
        check("ovf_set", 32'(overflow), 32'd1);
        evt = '0;
        clr_ovf = 1'b1;
        step();
        check("ovf_clr", 32'(overflow), 32'd0);
        clr_ovf = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        evt = 32'h20;
        step();
        step();
        check("sw_ovf", 32'(overflow), 32'd0);
        check("sw_pend", pending, 32'h20);
        check("sw_idx1", 32'(out_index), 32'd5);
        evt = '0;
        step();
        check("sw_idx2", 32'(out_index), 32'd5);
        check("sw_valid2", 32'(out_valid), 32'd1);
        step();

        evt = 32'h0F00;
        step();
        evt = '0;
        step();
        do_reset();
        step();
        check("mid_rst_idle", 32'(out_valid), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            evt = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : '0;
            mask = ($urandom_range(0, 7) == 0) ? $urandom : '1;
            out_ready = $urandom_range(0, 2) != 0;
            clr_ovf = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
